// File: rtl/pc_pkg.sv
// Shared types for the IF-stage PC generator and its return-address stack.
// Holds the next-PC source select and RAS operation encodings.
package pc_pkg;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_JMP,
    SEL_RET,
    SEL_BR,
    SEL_TRAP
  } sel_t;

  typedef enum logic [1:0] {
    RAS_NOP,
    RAS_PUSH,
    RAS_POP,
    RAS_SWAP
  } ras_op_t;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: push/pop/swap/flush, top entry view.
// Ports: clk_i, rst_i, flush_i, op_i, data_i -> top_o, empty_o, full_o.
module ras_stack
  import pc_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  ras_op_t         op_i,
  input  logic [XLEN-1:0] data_i,
  output logic [XLEN-1:0] top_o,
  output logic            empty_o,
  output logic            full_o
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]   ptr;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   ptr_inc;
  logic [PW-1:0]   ptr_dec;

  // Depth is a power of two, so pointer arithmetic wraps naturally.
  assign ptr_inc = ptr + PW'(1);
  assign ptr_dec = ptr - PW'(1);

  assign top_o   = mem[ptr];
  assign empty_o = (cnt == '0);
  assign full_o  = (cnt == CW'(RAS_DEPTH));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr <= '0;
      cnt <= '0;
    end else if (flush_i) begin
      cnt <= '0;
    end else begin
      case (op_i)
        RAS_PUSH: begin
          // When full the oldest slot is overwritten; count saturates.
          ptr <= ptr_inc;
          if (!full_o) cnt <= cnt + CW'(1);
        end
        RAS_POP: begin
          ptr <= ptr_dec;
          cnt <= cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_i) begin
      case (op_i)
        RAS_PUSH: mem[ptr_inc] <= data_i;
        RAS_SWAP: mem[ptr]     <= data_i;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pc_gen_ras.sv
// IF-stage PC generator: priority next-PC select, PC and redirect registers.
// Ports: control/targets from hazard, ID, EX -> pc_o, pc_plus_o, redirect_o, RAS flags.
module pc_gen_ras
  import pc_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'('h100),
  parameter int              INC       = 4,
  parameter int              RAS_DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            pc_wr_i,
  input  logic            trap_i,
  input  logic            branch_taken_i,
  input  logic [XLEN-1:0] branch_tgt_i,
  input  logic            jump_i,
  input  logic [XLEN-1:0] jump_tgt_i,
  input  logic            call_i,
  input  logic            ret_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus_o,
  output logic            redirect_o,
  output logic            ras_empty_o,
  output logic            ras_full_o
);

  logic            upd;
  logic            is_trap;
  logic            is_br;
  logic            is_ret;
  logic            is_jmp;
  sel_t            sel;
  ras_op_t         op_c;
  ras_op_t         ras_op;
  logic [XLEN-1:0] ras_top;
  logic [XLEN-1:0] pc_nxt;

  assign pc_plus_o = pc_o + XLEN'(INC);
  assign upd       = start_i & (pc_wr_i | trap_i);

  // One-hot qualified sources so the decoder below is truly unique.
  assign is_trap = trap_i;
  assign is_br   = branch_taken_i & ~trap_i;
  assign is_ret  = ret_i & ~ras_empty_o & ~trap_i & ~branch_taken_i;
  assign is_jmp  = jump_i & ~trap_i & ~branch_taken_i & ~is_ret;

  always_comb begin
    sel    = SEL_SEQ;
    op_c   = RAS_NOP;
    pc_nxt = pc_plus_o;
    unique case (1'b1)
      is_trap: begin
        sel    = SEL_TRAP;
        pc_nxt = TRAP_VEC;
      end
      is_br: begin
        sel    = SEL_BR;
        pc_nxt = branch_tgt_i;
      end
      is_ret: begin
        sel    = SEL_RET;
        pc_nxt = ras_top;
        // Return and call together: replace top instead of pop+push.
        op_c   = (jump_i & call_i) ? RAS_SWAP : RAS_POP;
      end
      is_jmp: begin
        sel    = SEL_JMP;
        pc_nxt = jump_tgt_i;
        op_c   = call_i ? RAS_PUSH : RAS_NOP;
      end
      default: ;
    endcase
  end

  assign ras_op = upd ? op_c : RAS_NOP;

  ras_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (upd & trap_i),
    .op_i    (ras_op),
    .data_i  (pc_plus_o),
    .top_o   (ras_top),
    .empty_o (ras_empty_o),
    .full_o  (ras_full_o)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_o       <= RESET_VEC;
      redirect_o <= 1'b0;
    end else if (upd) begin
      pc_o       <= pc_nxt;
      redirect_o <= (sel != SEL_SEQ);
    end
  end

endmodule
